// File: rtl/imem_loader.sv
// Instruction encoder and sequential loader for the instruction memory.
// Packs field bundles into RV32 words, seals the image with a halt word.
module imem_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_kind,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [20:0]           in_imm,
    input  logic                  in_last,
    output logic                  imem_we,
    output logic [DEPTH_LOG2-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEAL,
        DONE
    } state_t;

    localparam logic [2:0] K_R      = 3'd0;
    localparam logic [2:0] K_IALU   = 3'd1;
    localparam logic [2:0] K_LOAD   = 3'd2;
    localparam logic [2:0] K_STORE  = 3'd3;
    localparam logic [2:0] K_BRANCH = 3'd4;
    localparam logic [2:0] K_JAL    = 3'd5;
    localparam logic [2:0] K_JALR   = 3'd6;
    localparam logic [2:0] K_HALT   = 3'd7;

    localparam logic [31:0] HALT_WORD = 32'h0000_007F;

    // Last slot is reserved for halt; PTR_PRE is the last slot for program words.
    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;
    localparam logic [DEPTH_LOG2-1:0] PTR_PRE = {{(DEPTH_LOG2-1){1'b1}}, 1'b0};

    state_t                state_q;
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  we_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  hold_q;
    logic                  done_q;
    logic                  ovf_q;

    logic                  accept;
    logic [31:0]           word_d;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [20:0] imm
    );
        logic [31:0] w;
        w = 32'h0;
        unique case (kind)
            K_R:
                w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            K_IALU:
                w = {imm[11:0], rs1, f3, rd, 7'b0010011};
            K_LOAD:
                w = {imm[11:0], rs1, f3, rd, 7'b0000011};
            K_STORE:
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            K_BRANCH:
                w = {imm[12], imm[10:5], rs2, rs1, f3,
                     imm[4:1], imm[11], 7'b1100011};
            K_JAL:
                w = {imm[20], imm[10:1], imm[11], imm[19:12],
                     rd, 7'b1101111};
            K_JALR:
                w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            K_HALT:
                w = HALT_WORD;
            default:
                w = HALT_WORD;
        endcase
        return w;
    endfunction

    assign in_ready = (state_q == LOAD) && (ptr_q != PTR_MAX);
    assign accept   = in_valid && in_ready;

    assign word_d = encode(in_kind, in_rd, in_rs1, in_rs2,
                           in_funct3, in_funct7, in_imm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE) begin
                        done_q <= 1'b1;
                        hold_q <= 1'b0;
                    end
                    if (start) begin
                        state_q <= LOAD;
                        ptr_q   <= '0;
                        count_q <= '0;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        hold_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        we_q    <= 1'b1;
                        addr_q  <= ptr_q;
                        wdata_q <= word_d;
                        ptr_q   <= ptr_q + 1'b1;
                        count_q <= count_q + 1'b1;
                        if (in_kind == K_HALT) begin
                            state_q <= DONE;
                        end else if (in_last) begin
                            state_q <= SEAL;
                        end else if (ptr_q == PTR_PRE) begin
                            // Program filled every non-reserved slot.
                            ovf_q   <= 1'b1;
                            state_q <= SEAL;
                        end
                    end else if (ptr_q == PTR_MAX) begin
                        ovf_q   <= 1'b1;
                        state_q <= SEAL;
                    end
                end
                SEAL: begin
                    we_q    <= 1'b1;
                    addr_q  <= ptr_q;
                    wdata_q <= HALT_WORD;
                    count_q <= count_q + 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_hold  = hold_q;
    assign done       = done_q;
    assign count      = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued at accept
// time and matched (address, data, cycle) by an independent monitor.
module tb_imem_loader;

    localparam int DL   = 2;
    localparam int MAXP = (1 << DL) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_kind;
    logic [4:0]    in_rd, in_rs1, in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [20:0]   in_imm;
    logic          in_last;
    logic          imem_we;
    logic [DL-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          done;
    logic [DL:0]   count;
    logic          overflow;

    imem_loader #(.DEPTH_LOG2(DL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   exp_ptr = 0;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h want none",
                         imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                check("waddr", 32'(imem_addr), 32'(e.addr));
                check("wdata", imem_wdata, e.data);
                check("wcycle", cyc, e.cyc);
            end
        end
    end

    function automatic void push(int a, logic [31:0] d, int unsigned c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        exp_ptr = 0;
        check("start_hold", 32'(core_hold), 32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
        check("start_done", 32'(done), 32'd0);
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [6:0] f7,
                        input logic [20:0] imm, input logic last,
                        input logic [31:0] w);
        int n;
        n         = 0;
        in_valid  = 1'b1;
        in_kind   = k;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_last   = last;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=%b want 1 kind=%0d",
                     in_ready, k);
            in_valid = 1'b0;
            start    = 1'b0;
            return;
        end
        push(exp_ptr, w, cyc + 1);
        exp_ptr++;
        if (k != 3'd7 && (last || exp_ptr == MAXP)) begin
            push(exp_ptr, 32'h0000_007F, cyc + 2);
            exp_ptr++;
        end
        @(posedge clk);
        start = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic seal_check(input int cnt, input logic ovf);
        @(negedge clk);
        check("done_early", 32'(done), 32'd0);
        check("ready_seal", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("hold_rel", 32'(core_hold), 32'd0);
        check("count", 32'(count), 32'(cnt));
        check("overflow", 32'(overflow), 32'(ovf));
    endtask

    task automatic halt_check();
        @(negedge clk);
        check("halt_done", 32'(done), 32'd1);
        check("halt_hold", 32'(core_hold), 32'd0);
        check("halt_count", 32'(count), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_vals(string tag);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_hold"}, 32'(core_hold), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_kind   = '0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_funct3 = '0;
        in_funct7 = '0;
        in_imm    = '0;
        in_last   = 1'b0;
        repeat (2) @(negedge clk);
        reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // R add followed by sealing halt
        do_start();
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 21'd0, 1'b1, 32'h002081B3);
        seal_check(2, 1'b0);

        // back-to-back I-ALU then STORE
        do_start();
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd5, 1'b0, 32'h00500093);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 21'd8, 1'b1, 32'h0020A423);
        seal_check(3, 1'b0);

        // BRANCH then JAL, with a start pulse mid-load that must be ignored
        do_start();
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 21'h1FFFFC, 1'b0,
             32'hFE208EE3);
        start = 1'b1;
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd8, 1'b1, 32'h008000EF);
        seal_check(3, 1'b0);

        // overflow: valid held high, no last
        do_start();
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd1, 1'b0, 32'h00100093);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd2, 1'b0, 32'h00200093);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 21'd3, 1'b0, 32'h00300093);
        check("ovf_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        seal_check(4, 1'b1);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;

        // HALT with last: exactly one write, nothing appended
        do_start();
        send(3'd7, 5'd9, 5'd4, 5'd6, 3'd5, 7'd3, 21'h0ABCD, 1'b1,
             32'h0000007F);
        halt_check();

        // mid-load reset, then reload from address 0
        do_start();
        send(3'd0, 5'd5, 5'd6, 5'd7, 3'd4, 7'h20, 21'd0, 1'b0, 32'h407342B3);
        send(3'd6, 5'd1, 5'd5, 5'd0, 3'd3, 7'd0, 21'h1FFFF8, 1'b0,
             32'hFF8280E7);
        #2;
        rst_n = 1'b0;
        #1;
        reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 21'd0, 1'b1, 32'h0000007F);
        halt_check();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
